// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier for the EX stage: IDLE -> RUN -> DONE, fixed latency DATA_W/UNROLL+1.
// Optional macro MULT_SEQ_MULH_EN adds MULH/MULHSU/MULHU (2*DATA_W accumulator, sign handling).
module mult_sequencer #(
    parameter int DATA_W = 64,
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic              flush,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    // Handshake: start is sampled only in IDLE; stall holds the upstream
    // registers from the launch cycle through the last RUN cycle; done is a
    // one-cycle valid for result with no back-pressure (EX_MEM always takes it).

    localparam int STEPS = DATA_W / UNROLL;
    localparam int CNT_W = $clog2(STEPS) + 1;
`ifdef MULT_SEQ_MULH_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    count_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [ACC_W-1:0]    acc_step;
    logic [DATA_W-1:0]   result_d;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                launch;
    logic                last_step;

    assign launch    = (state_q == IDLE) && start && !flush;
    assign last_step = (count_q == CNT_W'(STEPS - 1));

`ifdef MULT_SEQ_MULH_EN
    logic [2:0]       func3_q;
    logic             sign_q;
    logic             a_neg;
    logic             b_neg;
    logic [ACC_W-1:0] prod;

    // The core only ever sees magnitudes; sign is reapplied to the full product.
    always_comb begin
        a_neg = ((func3 == 3'b001) || (func3 == 3'b010)) && op_a[DATA_W-1];
        b_neg = (func3 == 3'b001) && op_b[DATA_W-1];
        a_mag = a_neg ? (~op_a + DATA_W'(1)) : op_a;
        b_mag = b_neg ? (~op_b + DATA_W'(1)) : op_b;
    end

    always_comb begin
        prod = sign_q ? (~acc_step + ACC_W'(1)) : acc_step;
        case (func3_q)
            3'b000:                   result_d = prod[DATA_W-1:0];
            3'b001, 3'b010, 3'b011:   result_d = prod[ACC_W-1:DATA_W];
            default:                  result_d = '0;
        endcase
    end
`else
    logic unused_func3;

    assign unused_func3 = ^func3;
    assign a_mag        = op_a;
    assign b_mag        = op_b;
    assign result_d     = acc_step[DATA_W-1:0];
`endif

    // One RUN step: add the multiplicand, shifted per multiplier bit, for UNROLL bits.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (mplier_q[i]) begin
                acc_step = acc_step + (mcand_q << i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = start && !flush;
                if (enable && launch) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                stall = !flush;
                if (enable) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (last_step) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done = !flush;
                if (enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result   <= '0;
`ifdef MULT_SEQ_MULH_EN
            func3_q  <= '0;
            sign_q   <= 1'b0;
`endif
        end else if (enable) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        count_q  <= '0;
                        acc_q    <= '0;
                        mcand_q  <= ACC_W'(a_mag);
                        mplier_q <= b_mag;
`ifdef MULT_SEQ_MULH_EN
                        func3_q  <= func3;
                        sign_q   <= a_neg ^ b_neg;
`endif
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc_q    <= acc_step;
                        mcand_q  <= mcand_q << UNROLL;
                        mplier_q <= mplier_q >> UNROLL;
                        count_q  <= count_q + CNT_W'(1);
                        // Result is registered on entry to DONE so it is stable for the whole pulse.
                        if (last_step) begin
                            result <= result_d;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer (UNROLL=1 and UNROLL=4 instances).
// MULH expectations are compiled in when MULT_SEQ_MULH_EN is defined.
module tb_mult_sequencer;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic        start;
    logic        flush;
    logic [2:0]  func3;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        stall4;
    logic        busy4;
    logic        done4;
    logic [63:0] result4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mult_sequencer #(.DATA_W(64), .UNROLL(1)) u_dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .start(start), .flush(flush),
        .func3(func3), .op_a(op_a), .op_b(op_b),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    mult_sequencer #(.DATA_W(64), .UNROLL(4)) u_dut4 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .start(start), .flush(flush),
        .func3(func3), .op_a(op_a), .op_b(op_b),
        .stall(stall4), .busy(busy4), .done(done4), .result(result4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one op in cycle t (k=0) and observe until 3 cycles after done.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                          input logic sel4, output int lat, output int stall_cycles,
                          output int done_cycles, output logic [63:0] res);
        lat = -1;
        stall_cycles = 0;
        done_cycles = 0;
        res = '0;
        @(posedge clk); #1;
        op_a = a; op_b = b; func3 = f; start = 1'b1;
        @(negedge clk);
        if (sel4 ? stall4 : stall) stall_cycles++;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (sel4 ? stall4 : stall) stall_cycles++;
            if (sel4 ? done4 : done) begin
                done_cycles++;
                if (lat < 0) begin
                    lat = k;
                    res = sel4 ? result4 : result;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; enable = 1'b1; start = 1'b0; flush = 1'b0;
        func3 = 3'b000; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({stall, busy, done} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {stall, busy, done});
        else pass_cnt++;
        total_cnt++;
        if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result);
        else pass_cnt++;
        @(posedge clk); #1;
        arst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; int sc; int dc; logic [63:0] res;
        run_op(64'd3, 64'd5, 3'b000, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (lat !== 65) $display("FAIL basic_latency got %0d want 65", lat);
        else pass_cnt++;
        total_cnt++;
        if (sc !== 65) $display("FAIL basic_stall_cycles got %0d want 65", sc);
        else pass_cnt++;
        total_cnt++;
        if (dc !== 1) $display("FAIL basic_done_pulses got %0d want 1", dc);
        else pass_cnt++;
        total_cnt++;
        if (res !== 64'd15) $display("FAIL basic_result got %h want 15", res);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (result !== 64'd15) $display("FAIL basic_result_held got %h want 15", result);
        else pass_cnt++;
    endtask

    task automatic test_all_ones();
        int lat; int sc; int dc; logic [63:0] res; logic [63:0] exp_hu;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== 64'd1) $display("FAIL ones_mul got %h want 1", res);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 65) $display("FAIL ones_latency got %0d want 65", lat);
        else pass_cnt++;
        // func3=011: MULHU high half, or plain MUL when the high variants are absent.
`ifdef MULT_SEQ_MULH_EN
        exp_hu = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        exp_hu = 64'd1;
`endif
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== exp_hu) $display("FAIL ones_f3_011 got %h want %h", res, exp_hu);
        else pass_cnt++;
`ifdef MULT_SEQ_MULH_EN
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== 64'd0) $display("FAIL ones_mulh got %h want 0", res);
        else pass_cnt++;
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== 64'h4000_0000_0000_0000) $display("FAIL mulh_minneg got %h want 4000000000000000", res);
        else pass_cnt++;
        run_op(64'd3, 64'd5, 3'b100, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== 64'd0 || lat !== 65) $display("FAIL f3_1xx got %h lat %0d want 0 lat 65", res, lat);
        else pass_cnt++;
`endif
        run_op(64'd0, 64'd12345, 3'b000, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (res !== 64'd0 || lat !== 65) $display("FAIL zero_operand got %h lat %0d want 0 lat 65", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int lat; int sc; int dc; logic [63:0] res;
        @(posedge clk); #1;
        op_a = 64'd1000; op_b = 64'd1000; func3 = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({stall, done} !== 2'b00) $display("FAIL flush_cycle got stall,done=%b want 00", {stall, done});
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({stall, busy} !== 2'b00) $display("FAIL flush_next got stall,busy=%b want 00", {stall, busy});
        else pass_cnt++;
        run_op(64'd7, 64'd9, 3'b000, 1'b0, lat, sc, dc, res);
        total_cnt++;
        if (lat !== 65 || res !== 64'd63 || dc !== 1)
            $display("FAIL flush_restart got lat %0d res %h pulses %0d want 65 3f 1", lat, res, dc);
        else pass_cnt++;
    endtask

    task automatic test_enable_hold();
        int lat; int dc; logic [63:0] res; logic hold_ok;
        lat = -1; dc = 0; res = '0; hold_ok = 1'b1;
        @(posedge clk); #1;
        op_a = 64'd100; op_b = 64'd250; func3 = 3'b000; start = 1'b1;
        for (int k = 1; k < 150; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            enable = (k >= 20 && k < 27) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (k >= 20 && k < 27 && (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0)) hold_ok = 1'b0;
            if (done) begin
                dc++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
        end
        enable = 1'b1;
        total_cnt++;
        if (lat !== 72) $display("FAIL enable_latency got %0d want 72", lat);
        else pass_cnt++;
        total_cnt++;
        if (res !== 64'd25000 || dc !== 1) $display("FAIL enable_result got %h pulses %0d want 61a8 1", res, dc);
        else pass_cnt++;
        total_cnt++;
        if (hold_ok !== 1'b1) $display("FAIL enable_hold got %b want 1", hold_ok);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int dc;
        dc = 0;
        @(posedge clk); #1;
        op_a = 64'd9; op_b = 64'd9; func3 = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({stall, busy, done} !== 3'b000 || result !== 64'd0)
            $display("FAIL reset_mid_run got ctrl %b result %h want 000 0", {stall, busy, done}, result);
        else pass_cnt++;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        total_cnt++;
        if (dc !== 0) $display("FAIL reset_no_done got %0d want 0", dc);
        else pass_cnt++;
    endtask

    // start held high through the op, new op in ID_EX right after the done cycle
    task automatic test_back_to_back();
        int lat1; int lat2; logic [63:0] r1; logic [63:0] r2;
        lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        op_a = 64'd6; op_b = 64'd7; func3 = 3'b000; start = 1'b1;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk); #1;
            if (lat1 >= 0 && k == lat1 + 1) begin
                op_a = 64'd11; op_b = 64'd13;
            end
            if (lat2 >= 0) start = 1'b0;
            @(negedge clk);
            if (done) begin
                if (lat1 < 0) begin
                    lat1 = k; r1 = result;
                end else if (lat2 < 0) begin
                    lat2 = k; r2 = result;
                end
            end
            if (lat2 >= 0 && k >= lat2 + 2) break;
        end
        start = 1'b0;
        repeat (70) @(posedge clk);
        total_cnt++;
        if (lat1 !== 65 || r1 !== 64'd42) $display("FAIL b2b_first got lat %0d res %h want 65 2a", lat1, r1);
        else pass_cnt++;
        total_cnt++;
        if (lat2 !== 131 || r2 !== 64'd143) $display("FAIL b2b_second got lat %0d res %h want 131 8f", lat2, r2);
        else pass_cnt++;
    endtask

    task automatic test_unroll4();
        int lat; int sc; int dc; logic [63:0] res;
        run_op(64'h1234, 64'h10, 3'b000, 1'b1, lat, sc, dc, res);
        total_cnt++;
        if (lat !== 17) $display("FAIL unroll4_latency got %0d want 17", lat);
        else pass_cnt++;
        total_cnt++;
        if (res !== 64'h12340 || sc !== 17 || dc !== 1)
            $display("FAIL unroll4_result got %h stall %0d pulses %0d want 12340 17 1", res, sc, dc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_flush();
        test_enable_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_unroll4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
